// File: rtl/pulse_period_meter.sv
// pulse_period_meter
// Measures the number of clk cycles between successive rising edges of a
// (possibly asynchronous) input. Each completed period is reported with a
// one-cycle strobe. A sticky timeout flags a missing pulse: no edge for MAX
// cycles while measuring.
module pulse_period_meter #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2     // must be 2 or more
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             timeout,
    output logic             measuring
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s;
    logic                   edge_det;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    // Synchronizer chain plus previous-sample register for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= s;
        end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign edge_det = s & ~prev_q;

    // State and measurement registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: an edge always wins over the saturation/timeout path
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (edge_det) begin
                    // First edge only starts the measurement; nothing reported
                    count_d   = ONE;
                    timeout_d = 1'b0;
                    state_d   = MEASURE;
                end
            end
            MEASURE: begin
                if (edge_det) begin
                    period_d = count_q;
                    valid_d  = 1'b1;
                    count_d  = ONE;
                end else if (count_q == MAX) begin
                    // Counter never wraps; saturating means the pulse is lost
                    timeout_d = 1'b1;
                    count_d   = '0;
                    state_d   = IDLE;
                end else begin
                    count_d = count_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign timeout      = timeout_q;
    assign measuring    = (state_q == MEASURE);

endmodule
